byte_fifo: RTL

//  Synchronous first-word-fall-through byte FIFO. It decouples a byte producer from the 8-bit bus

---
 rtl/byte_fifo.sv | 98 +++++++++
 1 files changed

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with valid/ready on both sides.
// Exposes occupancy and sticky overflow/underflow attempt flags.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic full, empty, push, pop;

    // Full/empty come from the occupancy counter so flags never depend
    // combinationally on the handshake inputs.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & ~full;
    assign pop       = out_ready & ~empty;

    assign out_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (in_valid && full) begin
            ovf_d = 1'b1;
        end
        if (out_ready && empty) begin
            udf_d = 1'b1;
        end
    end

    // Control state; reset discards every queued entry at once.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is left uncleared on reset; head is read straight from it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
